axis_ddr_chk: RTL and testbench

AXIS_DDR_CHK -- requirements
Module: axis_ddr_chk

---
 rtl/axis_chk_pkg.sv | 17 +
 rtl/axis_chk_pattern.sv | 31 +++
 rtl/axis_ddr_chk.sv | 175 +++++++++++++++++
 tb/tb_axis_ddr_chk.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_chk_pkg.sv
// Shared types and constants for the AXI-Stream DDR read-data checker.
package axis_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chk_state_e;

    localparam int unsigned LANE_W         = 32;
    localparam logic [31:0] FIRST_ERR_NONE = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/axis_chk_pattern.sv
// Expected-data generator: every 32-bit lane carries seed + beat_index.
module axis_chk_pattern
    import axis_chk_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load_i,
    input  logic [31:0]           seed_i,
    input  logic                  adv_i,
    output logic [DATA_WIDTH-1:0] exp_data_o
);

    localparam int unsigned LANES = DATA_WIDTH / LANE_W;

    logic [LANE_W-1:0] word_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word_q <= '0;
        end else if (load_i) begin
            word_q <= seed_i;
        end else if (adv_i) begin
            word_q <= word_q + 32'd1;
        end
    end

    assign exp_data_o = {LANES{word_q}};

endmodule

// File: rtl/axis_ddr_chk.sv
// AXI-Stream DDR read-data checker: compares incoming bursts against a seeded
// counting pattern. Define AXIS_CHK_TIMEOUT_EN to enable the stall timeout.
module axis_ddr_chk
    import axis_chk_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned BURST_LENGTH   = 7,
    parameter int unsigned B_BURST_LENGTH = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    input  logic                    START_REG,
    input  logic [31:0]             NBURST_REG,
    input  logic [31:0]             SEED_REG,
    output logic                    IDLE_REG,
    output logic                    DONE_REG,
    output logic                    TIMEOUT_REG,
    output logic [31:0]             ERR_CNT_REG,
    output logic [31:0]             BEAT_CNT_REG,
    output logic [31:0]             CYCLE_CNT_REG,
    output logic [31:0]             FIRST_ERR_REG
);

    localparam logic [B_BURST_LENGTH-1:0] LAST_IDX = B_BURST_LENGTH'(BURST_LENGTH);

    chk_state_e                state_q;
    logic                      tready_q;
    logic                      idle_q;
    logic                      done_q;
    logic [31:0]               err_cnt_q;
    logic [31:0]               beat_cnt_q;
    logic [31:0]               cycle_cnt_q;
    logic [31:0]               first_err_q;
    logic [31:0]               nburst_q;
    logic [B_BURST_LENGTH-1:0] inburst_q;
    logic [31:0]               burst_cnt_q;

    logic                  start_run;
    logic                  hs;
    logic                  exp_last;
    logic                  beat_err;
    logic                  final_beat;
    logic                  stall_hit;
    logic [DATA_WIDTH-1:0] exp_data;
    logic                  unused_strb;

    assign start_run   = (state_q == ST_IDLE) && START_REG;
    assign hs          = s_axis_tvalid && tready_q;
    assign exp_last    = (inburst_q == LAST_IDX);
    assign beat_err    = (s_axis_tdata != exp_data) || (s_axis_tlast != exp_last);
    assign final_beat  = hs && exp_last && (burst_cnt_q == nburst_q - 32'd1);
    assign unused_strb = ^s_axis_tstrb;

    axis_chk_pattern #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pattern (
        .clk        (clk),
        .rstn       (rstn),
        .load_i     (start_run),
        .seed_i     (SEED_REG),
        .adv_i      (hs),
        .exp_data_o (exp_data)
    );

`ifdef AXIS_CHK_TIMEOUT_EN
    logic [31:0] stall_q;
    logic        timeout_q;

    // A handshake in the same cycle always wins over the stall limit.
    assign stall_hit = (state_q == ST_RUN) && !hs
                     && ((stall_q + 32'd1) >= 32'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else if (start_run) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else if (state_q == ST_RUN) begin
            stall_q <= hs ? '0 : stall_q + 32'd1;
            if (stall_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign TIMEOUT_REG = timeout_q;
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

    assign stall_hit   = 1'b0;
    assign TIMEOUT_REG = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            tready_q    <= 1'b0;
            idle_q      <= 1'b1;
            done_q      <= 1'b0;
            err_cnt_q   <= '0;
            beat_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            first_err_q <= FIRST_ERR_NONE;
            nburst_q    <= '0;
            inburst_q   <= '0;
            burst_cnt_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (START_REG) begin
                        state_q     <= ST_RUN;
                        // Zero bursts requested: nothing may be accepted.
                        tready_q    <= (NBURST_REG != '0);
                        idle_q      <= 1'b0;
                        nburst_q    <= NBURST_REG;
                        err_cnt_q   <= '0;
                        beat_cnt_q  <= '0;
                        cycle_cnt_q <= '0;
                        first_err_q <= FIRST_ERR_NONE;
                        inburst_q   <= '0;
                        burst_cnt_q <= '0;
                    end
                end
                ST_RUN: begin
                    cycle_cnt_q <= sat_inc(cycle_cnt_q);
                    if (hs) begin
                        beat_cnt_q <= beat_cnt_q + 32'd1;
                        if (beat_err) begin
                            err_cnt_q <= sat_inc(err_cnt_q);
                            if (err_cnt_q == '0) begin
                                first_err_q <= beat_cnt_q;
                            end
                        end
                        inburst_q <= exp_last ? '0 : inburst_q + 1'b1;
                        if (exp_last) begin
                            burst_cnt_q <= burst_cnt_q + 32'd1;
                        end
                    end
                    if ((nburst_q == '0) || final_beat || stall_hit) begin
                        state_q  <= ST_DONE;
                        tready_q <= 1'b0;
                        idle_q   <= 1'b1;
                        done_q   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!START_REG) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_axis_tready = tready_q;
    assign IDLE_REG      = idle_q;
    assign DONE_REG      = done_q;
    assign ERR_CNT_REG   = err_cnt_q;
    assign BEAT_CNT_REG  = beat_cnt_q;
    assign CYCLE_CNT_REG = cycle_cnt_q;
    assign FIRST_ERR_REG = first_err_q;

endmodule

// File: tb/tb_axis_ddr_chk.sv
// Self-checking bench for axis_ddr_chk; covers the timeout path when built
// with AXIS_CHK_TIMEOUT_EN.
module tb_axis_ddr_chk;

    localparam int DW = 64;
    localparam int BL = 7;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [DW/8-1:0] s_axis_tstrb = '0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic          START_REG = 1'b0;
    logic [31:0]   NBURST_REG = '0;
    logic [31:0]   SEED_REG = '0;
    logic          IDLE_REG, DONE_REG, TIMEOUT_REG;
    logic [31:0]   ERR_CNT_REG, BEAT_CNT_REG, CYCLE_CNT_REG, FIRST_ERR_REG;

    int checks = 0;
    int errors = 0;

    // Results of the most recent drive_run call
    int          r_cycles, r_last_hs, r_acc, r_exp_err;
    logic [31:0] r_exp_first;
    bit          r_hung;

    logic [DW-1:0] bdata [256];
    logic          blast [256];
    bit            bbad  [256];

    always #5 clk = ~clk;

    axis_ddr_chk #(
        .DATA_WIDTH     (DW),
        .BURST_LENGTH   (BL),
        .B_BURST_LENGTH (4),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .START_REG     (START_REG),
        .NBURST_REG    (NBURST_REG),
        .SEED_REG      (SEED_REG),
        .IDLE_REG      (IDLE_REG),
        .DONE_REG      (DONE_REG),
        .TIMEOUT_REG   (TIMEOUT_REG),
        .ERR_CNT_REG   (ERR_CNT_REG),
        .BEAT_CNT_REG  (BEAT_CNT_REG),
        .CYCLE_CNT_REG (CYCLE_CNT_REG),
        .FIRST_ERR_REG (FIRST_ERR_REG)
    );

    // Builds the beat stream from the pattern rule, runs it until the checker
    // leaves RUN, and accumulates the expected error count over accepted beats.
    task automatic drive_run(input int nb, input logic [31:0] seed, input int valid_pct,
                             input int bad_data_beat, input int no_last_beat,
                             input int rand_err_pct, input int present_max, input bit drop_start);
        int total;
        int limit;
        bit v;
        bit hs;
        total = nb * (BL + 1);
        limit = (present_max < total) ? present_max : total;
        for (int i = 0; i < total; i++) begin
            logic [31:0] w;
            logic [DW-1:0] good;
            logic gl;
            w    = seed + 32'(i);
            good = {2{w}};
            gl   = ((i % (BL + 1)) == BL);
            bdata[i] = good;
            blast[i] = gl;
            if (i == bad_data_beat) bdata[i][7:0] = bdata[i][7:0] ^ 8'h5A;
            if (i == no_last_beat)  blast[i] = 1'b0;
            if (int'($urandom_range(99)) < rand_err_pct) begin
                if ($urandom_range(1) == 0) bdata[i] = bdata[i] ^ (64'd1 << $urandom_range(63));
                else                        blast[i] = ~blast[i];
            end
            bbad[i] = (bdata[i] != good) || (blast[i] != gl);
        end
        NBURST_REG  = 32'(nb);
        SEED_REG    = seed;
        START_REG   = 1'b1;
        r_cycles    = 0;
        r_last_hs   = 0;
        r_acc       = 0;
        r_exp_err   = 0;
        r_exp_first = 32'hFFFF_FFFF;
        r_hung      = 0;
        @(posedge clk); #1;
        if (drop_start) START_REG = 1'b0;
        while (!IDLE_REG) begin
            if (r_cycles >= 3000) begin
                r_hung = 1;
                break;
            end
            r_cycles++;
            v = (r_acc < limit) && (int'($urandom_range(99)) < valid_pct);
            s_axis_tvalid = v;
            s_axis_tdata  = v ? bdata[r_acc] : {$urandom, $urandom};
            s_axis_tlast  = v ? blast[r_acc] : 1'($urandom);
            s_axis_tstrb  = 8'($urandom);
            hs = v && s_axis_tready;
            @(posedge clk); #1;
            if (hs) begin
                if (bbad[r_acc]) begin
                    if (r_exp_err == 0) r_exp_first = 32'(r_acc);
                    r_exp_err++;
                end
                r_acc++;
                r_last_hs = r_cycles;
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic stop_run();
        START_REG = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        START_REG = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (IDLE_REG !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", IDLE_REG); end
        checks++; if (DONE_REG !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", DONE_REG); end
        checks++; if (TIMEOUT_REG !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", TIMEOUT_REG); end
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b want 0", s_axis_tready); end
        checks++; if ({ERR_CNT_REG, BEAT_CNT_REG, CYCLE_CNT_REG} !== 96'd0) begin errors++;
            $display("FAIL reset_counters got %h %h %h want 0", ERR_CNT_REG, BEAT_CNT_REG, CYCLE_CNT_REG); end
        checks++; if (FIRST_ERR_REG !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_first_err got %h want ffffffff", FIRST_ERR_REG); end
        #3 rstn = 1'b1;
        @(posedge clk); #1;
        checks++; if (IDLE_REG !== 1'b1) begin errors++; $display("FAIL post_reset_idle got %b want 1", IDLE_REG); end
    endtask

    task automatic test_clean_run();
        drive_run(4, 32'h100, 100, -1, -1, 0, 1000, 0);
        checks++; if (r_hung) begin errors++; $display("FAIL clean_hung got 1 want 0"); end
        checks++; if (DONE_REG !== 1'b1) begin errors++; $display("FAIL clean_done got %b want 1", DONE_REG); end
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL clean_tready got %b want 0", s_axis_tready); end
        checks++; if (BEAT_CNT_REG !== 32'd32) begin errors++; $display("FAIL clean_beats got %0d want 32", BEAT_CNT_REG); end
        checks++; if (ERR_CNT_REG !== 32'd0) begin errors++; $display("FAIL clean_errs got %0d want 0", ERR_CNT_REG); end
        checks++; if (FIRST_ERR_REG !== 32'hFFFF_FFFF) begin errors++; $display("FAIL clean_first got %h want ffffffff", FIRST_ERR_REG); end
        checks++; if (CYCLE_CNT_REG !== 32'd32) begin errors++; $display("FAIL clean_cycles got %0d want 32", CYCLE_CNT_REG); end
        checks++; if (r_cycles != 32) begin errors++; $display("FAIL clean_run_len got %0d want 32", r_cycles); end
        checks++; if (TIMEOUT_REG !== 1'b0) begin errors++; $display("FAIL clean_timeout got %b want 0", TIMEOUT_REG); end
        stop_run();
        checks++; if (DONE_REG !== 1'b0 || IDLE_REG !== 1'b1) begin errors++;
            $display("FAIL clean_back_idle got done=%b idle=%b want 0 1", DONE_REG, IDLE_REG); end
    endtask

    task automatic test_errors();
        drive_run(4, 32'h100, 100, 9, 15, 0, 1000, 0);
        checks++; if (ERR_CNT_REG !== 32'd2) begin errors++; $display("FAIL err_count got %0d want 2", ERR_CNT_REG); end
        checks++; if (FIRST_ERR_REG !== 32'd9) begin errors++; $display("FAIL err_first got %0d want 9", FIRST_ERR_REG); end
        checks++; if (BEAT_CNT_REG !== 32'd32) begin errors++; $display("FAIL err_beats got %0d want 32", BEAT_CNT_REG); end
        stop_run();
    endtask

    task automatic test_nburst_zero();
        drive_run(0, $urandom, 100, -1, -1, 0, 1000, 0);
        checks++; if (r_cycles != 1) begin errors++; $display("FAIL zero_run_len got %0d want 1", r_cycles); end
        checks++; if (CYCLE_CNT_REG !== 32'd1) begin errors++; $display("FAIL zero_cycles got %0d want 1", CYCLE_CNT_REG); end
        checks++; if (BEAT_CNT_REG !== 32'd0) begin errors++; $display("FAIL zero_beats got %0d want 0", BEAT_CNT_REG); end
        checks++; if (DONE_REG !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", DONE_REG); end
        stop_run();
    endtask

    task automatic test_throttled();
        drive_run(2, $urandom, 50, -1, -1, 0, 1000, 1);
        checks++; if (r_hung) begin errors++; $display("FAIL thr_hung got 1 want 0"); end
        checks++; if (BEAT_CNT_REG !== 32'd16) begin errors++; $display("FAIL thr_beats got %0d want 16", BEAT_CNT_REG); end
        checks++; if (CYCLE_CNT_REG !== 32'(r_cycles)) begin errors++; $display("FAIL thr_cycles got %0d want %0d", CYCLE_CNT_REG, r_cycles); end
        checks++; if (r_cycles != r_last_hs) begin errors++; $display("FAIL thr_exit got %0d want %0d", r_cycles, r_last_hs); end
        checks++; if (ERR_CNT_REG !== 32'd0) begin errors++; $display("FAIL thr_errs got %0d want 0", ERR_CNT_REG); end
        @(posedge clk); #1;
        checks++; if (IDLE_REG !== 1'b1 || DONE_REG !== 1'b0 || BEAT_CNT_REG !== 32'd16) begin errors++;
            $display("FAIL thr_hold got idle=%b done=%b beats=%0d want 1 0 16", IDLE_REG, DONE_REG, BEAT_CNT_REG); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            int nb;
            nb = int'($urandom_range(4, 1));
            drive_run(nb, $urandom, int'($urandom_range(100, 30)), -1, -1, 15, 1000, 0);
            checks++; if (BEAT_CNT_REG !== 32'(nb * 8)) begin errors++; $display("FAIL rnd_beats got %0d want %0d", BEAT_CNT_REG, nb * 8); end
            checks++; if (ERR_CNT_REG !== 32'(r_exp_err)) begin errors++; $display("FAIL rnd_errs got %0d want %0d", ERR_CNT_REG, r_exp_err); end
            checks++; if (FIRST_ERR_REG !== r_exp_first) begin errors++; $display("FAIL rnd_first got %h want %h", FIRST_ERR_REG, r_exp_first); end
            checks++; if (CYCLE_CNT_REG !== 32'(r_last_hs)) begin errors++; $display("FAIL rnd_cycles got %0d want %0d", CYCLE_CNT_REG, r_last_hs); end
            stop_run();
        end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] seed;
        seed = $urandom;
        NBURST_REG = 32'd4;
        SEED_REG   = seed;
        START_REG  = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = {2{seed + 32'(i)}};
            s_axis_tlast  = 1'b0;
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0;
        checks++; if (BEAT_CNT_REG !== 32'd5) begin errors++; $display("FAIL mid_beats got %0d want 5", BEAT_CNT_REG); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (IDLE_REG !== 1'b1 || DONE_REG !== 1'b0 || s_axis_tready !== 1'b0) begin errors++;
            $display("FAIL mid_reset_flags got idle=%b done=%b rdy=%b want 1 0 0", IDLE_REG, DONE_REG, s_axis_tready); end
        checks++; if (BEAT_CNT_REG !== 32'd0 || CYCLE_CNT_REG !== 32'd0 || FIRST_ERR_REG !== 32'hFFFF_FFFF) begin errors++;
            $display("FAIL mid_reset_cnt got %0d %0d %h want 0 0 ffffffff", BEAT_CNT_REG, CYCLE_CNT_REG, FIRST_ERR_REG); end
        START_REG = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;
        drive_run(1, $urandom, 100, -1, -1, 0, 1000, 0);
        checks++; if (BEAT_CNT_REG !== 32'd8) begin errors++; $display("FAIL restart_beats got %0d want 8", BEAT_CNT_REG); end
        checks++; if (ERR_CNT_REG !== 32'd0 || CYCLE_CNT_REG !== 32'd8) begin errors++;
            $display("FAIL restart_cnt got err=%0d cyc=%0d want 0 8", ERR_CNT_REG, CYCLE_CNT_REG); end
        stop_run();
    endtask

    task automatic test_timeout();
`ifdef AXIS_CHK_TIMEOUT_EN
        drive_run(2, $urandom, 0, -1, -1, 0, 0, 0);
        checks++; if (r_cycles != TO) begin errors++; $display("FAIL to_run_len got %0d want %0d", r_cycles, TO); end
        checks++; if (TIMEOUT_REG !== 1'b1 || DONE_REG !== 1'b1) begin errors++;
            $display("FAIL to_flags got to=%b done=%b want 1 1", TIMEOUT_REG, DONE_REG); end
        checks++; if (BEAT_CNT_REG !== 32'd0 || CYCLE_CNT_REG !== 32'(TO)) begin errors++;
            $display("FAIL to_cnt got beats=%0d cyc=%0d want 0 %0d", BEAT_CNT_REG, CYCLE_CNT_REG, TO); end
        stop_run();
        drive_run(2, $urandom, 100, -1, -1, 0, 3, 0);
        checks++; if (r_cycles != 3 + TO || BEAT_CNT_REG !== 32'd3 || TIMEOUT_REG !== 1'b1) begin errors++;
            $display("FAIL to_after_beats got len=%0d beats=%0d to=%b want %0d 3 1", r_cycles, BEAT_CNT_REG, TIMEOUT_REG, 3 + TO); end
        stop_run();
        drive_run(1, $urandom, 100, -1, -1, 0, 1000, 0);
        checks++; if (TIMEOUT_REG !== 1'b0 || BEAT_CNT_REG !== 32'd8) begin errors++;
            $display("FAIL to_cleared got to=%b beats=%0d want 0 8", TIMEOUT_REG, BEAT_CNT_REG); end
        stop_run();
`else
        NBURST_REG    = 32'd2;
        START_REG     = 1'b1;
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
        repeat (40) @(posedge clk);
        #1;
        checks++; if (IDLE_REG !== 1'b0 || TIMEOUT_REG !== 1'b0) begin errors++;
            $display("FAIL no_to_stay got idle=%b to=%b want 0 0", IDLE_REG, TIMEOUT_REG); end
        checks++; if (CYCLE_CNT_REG !== 32'd40) begin errors++; $display("FAIL no_to_cycles got %0d want 40", CYCLE_CNT_REG); end
        START_REG = 1'b0;
        rstn = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;
`endif
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_errors();
        test_nburst_zero();
        test_throttled();
        test_random();
        test_reset_midrun();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
